fpga_test_controller: RTL



---
 rtl/fpga_test_pkg.sv | 31 +++
 rtl/test_signature_match.sv | 19 +
 rtl/fpga_test_controller.sv | 107 ++++++++++
 3 files changed

// File: rtl/fpga_test_pkg.sv
// Shared types and constants for the FPGA test controller: state encoding,
// LED bit positions and the per-state LED patterns.
package fpga_test_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    RUN  = 2'b01,
    PASS = 2'b10,
    FAIL = 2'b11
  } state_e;

  localparam int LED_RUN  = 3;
  localparam int LED_OK   = 2;
  localparam int LED_FAIL = 1;
  localparam int LED_PWR  = 0;

  localparam logic [3:0] LEDS_HOLD = 4'b0001;
  localparam logic [3:0] LEDS_RUN  = 4'b1001;
  localparam logic [3:0] LEDS_PASS = 4'b0101;
  localparam logic [3:0] LEDS_FAIL = 4'b0011;

  function automatic logic [3:0] led_pattern(input state_e st);
    case (st)
      RUN:     return LEDS_RUN;
      PASS:    return LEDS_PASS;
      FAIL:    return LEDS_FAIL;
      default: return LEDS_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/test_signature_match.sv
// Combinational detector for the test program's completion signature write.
module test_signature_match #(
  parameter logic [31:0] PASS_ADDR = 32'h00000054,
  parameter logic [31:0] PASS_DATA = 32'h00000007
) (
  input  logic        memwrite_i,
  input  logic [31:0] dataadr_i,
  input  logic [31:0] writedata_i,
  output logic        hit_pass_o,
  output logic        hit_fail_o
);

  logic addr_hit;

  assign addr_hit   = memwrite_i && (dataadr_i == PASS_ADDR);
  assign hit_pass_o = addr_hit && (writedata_i == PASS_DATA);
  assign hit_fail_o = addr_hit && (writedata_i != PASS_DATA);

endmodule

// File: rtl/fpga_test_controller.sv
// Holds the MIPS core in reset, runs it, watches for the pass/fail signature
// and drives the status LEDs. Optional LED heartbeat: TESTCTL_BLINK_EN.
module fpga_test_controller
  import fpga_test_pkg::*;
#(
  parameter int          RESET_HOLD     = 16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1048576,
  parameter logic [31:0] PASS_ADDR      = 32'h00000054,
  parameter logic [31:0] PASS_DATA      = 32'h00000007,
  parameter int          BLINK_BITS     = 22
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        cpu_reset,
  output logic [3:0]  outputleds,
  output logic [31:0] cycles
);

  localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);

  state_e          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [31:0]     cycles_q, cycles_d;
  logic [3:0]      led_q, led_d;
  logic            hit_pass, hit_fail;

  test_signature_match #(
    .PASS_ADDR (PASS_ADDR),
    .PASS_DATA (PASS_DATA)
  ) u_match (
    .memwrite_i  (memwrite),
    .dataadr_i   (dataadr),
    .writedata_i (writedata),
    .hit_pass_o  (hit_pass),
    .hit_fail_o  (hit_fail)
  );

  always_ff @(posedge ph1) begin
    if (reset) begin
      state_q  <= HOLD;
      hold_q   <= '0;
      cycles_q <= '0;
      led_q    <= LEDS_HOLD;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      cycles_q <= cycles_d;
      led_q    <= led_d;
    end
  end

  // Signature checks precede the timeout so a write on the timeout cycle wins.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    cycles_d = cycles_q;
    case (state_q)
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN: begin
        if (hit_pass) begin
          state_d = PASS;
        end else if (hit_fail) begin
          state_d = FAIL;
        end else if (cycles_q >= TIMEOUT_CYCLES) begin
          state_d = FAIL;
        end else if (cycles_q != 32'hFFFFFFFF) begin
          cycles_d = cycles_q + 32'd1;
        end
      end
      default: ;
    endcase
  end

`ifdef TESTCTL_BLINK_EN
  logic [BLINK_BITS-1:0] presc_q;

  always_ff @(posedge ph1) begin
    if (reset) presc_q <= '0;
    else       presc_q <= presc_q + 1'b1;
  end

  always_comb begin
    led_d = led_pattern(state_q);
    if (state_q == RUN) led_d[LED_RUN] = presc_q[BLINK_BITS-1];
  end
`else
  always_comb begin
    led_d = led_pattern(state_q);
  end
`endif

  assign cpu_reset  = reset | (state_q == HOLD);
  assign outputleds = led_q;
  assign cycles     = cycles_q;

endmodule
